i2s_transmitter: RTL

- I2S master transmitter: the output direction of the mic capture path.
- Accepts stereo 16-bit PCM samples through a valid/ready handshake.
- Generates BCLK and LRCLK from the 50 MHz system clock and serialises samples MSB-first onto DIN for an external I2S DAC/amplifier.
- Used to play back or monitor audio from the FFT/visualiser pipeline; owns all I2S clocks (master mode).

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_clk_gen.sv | 66 ++++++
 rtl/i2s_transmitter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default geometry, sample type and LRCLK channel encoding.
package i2s_pkg;

    localparam int unsigned DEF_CLK_DIV  = 8;
    localparam int unsigned DEF_SAMPLE_W = 16;
    localparam int unsigned DEF_SLOT_W   = 32;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } lr_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master clock generator: BCLK divider, frame bit counter and LRCLK.
// Emits same-cycle fall/frame strobes and the next bit index; shareable with the receiver.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter  int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter  int unsigned SLOT_W  = DEF_SLOT_W,
    localparam int unsigned BW      = $clog2(2 * SLOT_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          o_bclk,
    output logic          o_lrclk,
    output logic          o_fall,
    output logic          o_frame_start,
    output logic [BW-1:0] o_bit_next
);

    localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0]    BIT_RIGHT = BW'(SLOT_W);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    lr_t              r_lr;
    logic [BW-1:0]    r_bit;

    logic             w_tc;
    logic             w_fall;
    logic [BW-1:0]    w_bit_next;

    always_comb begin
        w_tc       = (r_div == DIV_LAST);
        w_fall     = w_tc && r_bclk;
        w_bit_next = (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
    end

    // Reset parks the bit counter on the last bit so the first fall is a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
            r_lr   <= LEFT;
            r_bit  <= BIT_LAST;
        end else begin
            if (w_tc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit <= w_bit_next;
                r_lr  <= (w_bit_next >= BIT_RIGHT) ? RIGHT : LEFT;
            end
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrclk       = r_lr;
    assign o_fall        = w_fall;
    assign o_frame_start = w_fall && (r_bit == BIT_LAST);
    assign o_bit_next    = w_bit_next;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-entry holding buffer, per-frame active pair and MSB-first DIN.
// Define I2S_TX_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise it reads 0.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
    parameter int unsigned SLOT_W   = DEF_SLOT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                DIN,
    output logic                frame_start,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int unsigned BW = $clog2(2 * SLOT_W);

    logic                w_fall;
    logic                w_frame;
    logic [BW-1:0]       w_bit_next;

    logic [SAMPLE_W-1:0] r_hold_l;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic [SAMPLE_W-1:0] r_act_l;
    logic [SAMPLE_W-1:0] r_act_r;
    logic                r_full;
    logic                r_ready;
    logic                r_din;
    logic                r_frame;
    logic                r_underrun;

    logic                w_xfer;
    logic                w_full_next;
    logic                w_right;
    logic [BW-1:0]       w_slot;
    logic [SAMPLE_W-1:0] w_word;
    logic [SAMPLE_W-1:0] w_shifted;
    logic                w_din_next;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .SLOT_W  (SLOT_W)
    ) u_clk_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_bclk        (BCLK),
        .o_lrclk       (LRCLK),
        .o_fall        (w_fall),
        .o_frame_start (w_frame),
        .o_bit_next    (w_bit_next)
    );

    // DIN is looked up from the bit index that becomes current on this fall.
    always_comb begin
        w_xfer      = sample_valid && r_ready;
        w_full_next = w_xfer || (r_full && !w_frame);
        w_right     = (w_bit_next >= BW'(SLOT_W));
        w_slot      = w_right ? (w_bit_next - BW'(SLOT_W)) : w_bit_next;
        w_word      = w_right ? r_act_r : r_act_l;
        w_shifted   = w_word >> (BW'(SAMPLE_W) - w_slot);
        w_din_next  = (w_slot != '0) && (w_slot <= BW'(SAMPLE_W)) && w_shifted[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_act_l    <= '0;
            r_act_r    <= '0;
            r_full     <= 1'b0;
            r_ready    <= 1'b1;
            r_din      <= 1'b0;
            r_frame    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_frame    <= w_frame;
            r_underrun <= w_frame && !r_full;
            r_full     <= w_full_next;
            r_ready    <= !w_full_next;
            if (w_fall) begin
                r_din <= w_din_next;
            end
            if (w_frame) begin
                r_act_l <= r_full ? r_hold_l : '0;
                r_act_r <= r_full ? r_hold_r : '0;
            end
            if (w_xfer) begin
                r_hold_l <= sample_l;
                r_hold_r <= sample_r;
            end
        end
    end

    assign sample_ready = r_ready;
    assign DIN          = r_din;
    assign frame_start  = r_frame;
    assign underrun     = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_ucnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ucnt <= '0;
        end else if (w_frame && !r_full && (r_ucnt != '1)) begin
            r_ucnt <= r_ucnt + 16'd1;
        end
    end

    assign underrun_cnt = r_ucnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule
